spi_sram_bridge: RTL

//  Parametrised command bridge between the SPI slave and a single-port synchronous SRAM macro.
//  - Decodes {cmd[1:0], payload} words from the SPI slave into SRAM write and read cycles.
//  - Keeps separate write and read address registers, so address and data travel in separate frames.
//  - Returns read data to the slave over tx_valid/tx_data.
//  - Sits between the SPI slave and the SRAM in the SPI-to-SRAM top level.

---
 rtl/spi_sram_bridge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_sram_bridge.sv
// spi_sram_bridge: decodes SPI command words into single-port SRAM write/read cycles.
// Optional `SRAM_BRIDGE_AUTOINC_EN: post-increment the write/read pointers after each access.
module spi_sram_bridge #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0,
  output logic              err,
  input  logic              clr_err
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_DONE = 3'd4;
  localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, addr0_q, addr0_d;
  logic [DATA_W-1:0] din0_q, din0_d, tx_data_q, tx_data_d;
  logic              wa_vld_q, wa_vld_d, ra_vld_q, ra_vld_d, err_q, err_d;
  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  assign cmd      = rx_data[DATA_W+1:DATA_W];
  assign payload  = rx_data[DATA_W-1:0];
  assign rx_ready = state_q == S_IDLE;
  assign accept   = rx_valid && rx_ready;
  assign csb0     = !(state_q == S_WR || state_q == S_RD_REQ);
  assign web0     = state_q != S_WR;
  assign tx_valid = state_q == S_RD_DONE;
  assign addr0    = addr0_q;
  assign din0     = din0_q;
  assign tx_data  = tx_data_q;
  assign err      = err_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wa_vld_d  = wa_vld_q;
    ra_vld_d  = ra_vld_q;
    addr0_d   = addr0_q;
    din0_d    = din0_q;
    tx_data_d = tx_data_q;
    // clear applies to the old flag; an error in this same cycle still sets it
    err_d = (clr_err ? 1'b0 : err_q) | (rx_valid && !rx_ready)
          | (accept && cmd == 2'b01 && !wa_vld_q) | (accept && cmd == 2'b11 && !ra_vld_q);
    case (state_q)
      S_IDLE: if (accept) begin
        case (cmd)
          2'b00: begin
            wr_addr_d = payload[ADDR_W-1:0];
            wa_vld_d  = 1'b1;
          end
          2'b10: begin
            rd_addr_d = payload[ADDR_W-1:0];
            ra_vld_d  = 1'b1;
          end
          2'b01: if (wa_vld_q) begin
            din0_d  = payload;
            addr0_d = wr_addr_q;
            state_d = S_WR;
          end
          default: if (ra_vld_q) begin
            addr0_d = rd_addr_q;
            state_d = S_RD_REQ;
          end
        endcase
      end
      S_WR: begin
        state_d = S_IDLE;
`ifdef SRAM_BRIDGE_AUTOINC_EN
        wr_addr_d = wr_addr_q + 1'b1;
`endif
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        cnt_d   = CW'(READ_LAT - 1);
      end
      S_RD_WAIT: if (cnt_q == '0) begin
        tx_data_d = dout0;
        state_d   = S_RD_DONE;
`ifdef SRAM_BRIDGE_AUTOINC_EN
        rd_addr_d = rd_addr_q + 1'b1;
`endif
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wa_vld_q  <= 1'b0;
      ra_vld_q  <= 1'b0;
      addr0_q   <= '0;
      din0_q    <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wa_vld_q  <= wa_vld_d;
      ra_vld_q  <= ra_vld_d;
      addr0_q   <= addr0_d;
      din0_q    <= din0_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end
endmodule
